// File: rtl/syndrome_gen_pkg.sv
// rtl/syndrome_gen_pkg.sv - shared code dimensions, types and state encoding for the syndrome generator
package syndrome_gen_pkg;

    localparam int Q      = 3;
    localparam int T      = 2;
    localparam int N_MSG  = Q * Q;
    localparam int N_ROWS = 2 * T * Q;
    localparam int K_LEN  = N_MSG + N_ROWS;
    localparam int LOGN   = 4;

    typedef logic [K_LEN-1:0]  cw_t;
    typedef logic [N_ROWS-1:0] syn_t;
    typedef logic [LOGN-1:0]   row_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_CIPHER = 2'd1,
        ST_ACCUM       = 2'd2,
        ST_DONE        = 2'd3
    } state_t;

endpackage

// File: rtl/syndrome_gen_if.sv
// rtl/syndrome_gen_if.sv - cipher/parity-row inputs and syndrome result bundle
interface syndrome_gen_if;
    import syndrome_gen_pkg::*;

    logic     start;
    logic     cipher_ready;
    cw_t      cipher;
    logic     parity_ready;
    cw_t      parity_check_row;
    logic     row_req;
    row_idx_t row_idx;
    syn_t     syndrome;
    logic     syndrome_ready;
    logic     error_free;

    modport master (
        output start, cipher_ready, cipher, parity_ready, parity_check_row,
        input  row_req, row_idx, syndrome, syndrome_ready, error_free
    );

    modport slave (
        input  start, cipher_ready, cipher, parity_ready, parity_check_row,
        output row_req, row_idx, syndrome, syndrome_ready, error_free
    );

endinterface

// File: rtl/syndrome_gen_parity_dot.sv
// rtl/syndrome_gen_parity_dot.sv - GF(2) dot product of a parity-check row and a codeword
module parity_dot #(
    parameter int W = 21
) (
    input  logic [W-1:0] row,
    input  logic [W-1:0] vec,
    output logic         dot
);

    assign dot = ^(row & vec);

endmodule

// File: rtl/syndrome_gen.sv
// rtl/syndrome_gen.sv - streams parity-check rows against a latched cipher and assembles the syndrome
module syndrome_gen
    import syndrome_gen_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    syndrome_gen_if.slave  bus
);

    localparam row_idx_t LAST_ROW = row_idx_t'(N_ROWS - 1);

    state_t   state_q, state_d;
    row_idx_t cnt_q, cnt_d;
    cw_t      cipher_q, cipher_d;
    syn_t     syn_q, syn_d;
    logic     rdy_q, rdy_d;
    logic     ef_q, ef_d;
    logic     dot_bit;

    parity_dot #(.W(K_LEN)) u_parity_dot (
        .row (bus.parity_check_row),
        .vec (cipher_q),
        .dot (dot_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cipher_q <= '0;
            syn_q    <= '0;
            rdy_q    <= 1'b0;
            ef_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cipher_q <= cipher_d;
            syn_q    <= syn_d;
            rdy_q    <= rdy_d;
            ef_q     <= ef_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cipher_d = cipher_q;
        syn_d    = syn_q;
        rdy_d    = rdy_q;
        ef_d     = ef_q;

        // start overrides everything, including a coincident cipher strobe or row
        if (bus.start) begin
            state_d = ST_WAIT_CIPHER;
            cnt_d   = '0;
            syn_d   = '0;
            rdy_d   = 1'b0;
            ef_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_WAIT_CIPHER: begin
                    if (bus.cipher_ready) begin
                        cipher_d = bus.cipher;
                        state_d  = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (bus.parity_ready) begin
                        syn_d[cnt_q] = dot_bit;
                        if (cnt_q == LAST_ROW) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    rdy_d = 1'b1;
                    ef_d  = (syn_q == '0);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.row_req        = (state_q == ST_ACCUM);
    assign bus.row_idx        = cnt_q;
    assign bus.syndrome       = syn_q;
    assign bus.syndrome_ready = rdy_q;
    assign bus.error_free     = ef_q;

endmodule

// File: tb/tb_syndrome_gen.sv
// tb/tb_syndrome_gen.sv - scoreboard bench for syndrome_gen with directed cipher/H vectors
module tb_syndrome_gen;
    import syndrome_gen_pkg::*;

    typedef struct {
        syn_t syn;
        logic ef;
        int   lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    syndrome_gen_if bus();

    syndrome_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   latch_cyc = 0;
    logic prev_req = 1'b0;
    logic prev_rdy = 1'b0;
    exp_t exp_q[$];
    cw_t  h_rows[N_ROWS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // latency is measured from the edge that latched the cipher (row_req rising)
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.row_req && !prev_req) latch_cyc = cyc;
        if (bus.syndrome_ready && !prev_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: syndrome 0x%0h arrived with nothing expected", bus.syndrome);
            end else begin
                e = exp_q.pop_front();
                check("sb_syndrome", 32'(bus.syndrome), 32'(e.syn));
                check("sb_error_free", 32'(bus.error_free), 32'(e.ef));
                check("sb_latency", cyc - latch_cyc, e.lat);
            end
        end
        prev_req = bus.row_req;
        prev_rdy = bus.syndrome_ready;
    end

    task automatic start_and_latch(input cw_t c, input int early);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_clears_ready", 32'(bus.syndrome_ready), 0);
        check("start_clears_syndrome", 32'(bus.syndrome), 0);
        for (int i = 0; i < early; i++) begin
            bus.parity_ready     = 1'b1;
            bus.parity_check_row = h_rows[i];
            @(negedge clk);
            check("early_row_req", 32'(bus.row_req), 0);
            check("early_row_idx", 32'(bus.row_idx), 0);
        end
        bus.parity_ready = 1'b0;
        bus.cipher       = c;
        bus.cipher_ready = 1'b1;
        @(negedge clk);
        bus.cipher_ready = 1'b0;
        bus.cipher       = ~c;
    endtask

    task automatic wait_ready(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.syndrome_ready) break;
            @(negedge clk);
        end
        check("ready_within_bound", 32'(bus.syndrome_ready), 1);
    endtask

    task automatic do_op(input cw_t c, input bit stall, input int early,
                         input syn_t exp_syn, input int exp_lat);
        exp_t e;
        int   idx;
        int   k;
        start_and_latch(c, early);
        e.syn = exp_syn;
        e.ef  = (exp_syn == '0);
        e.lat = exp_lat;
        exp_q.push_back(e);
        idx = 0;
        k   = 0;
        while (bus.row_req && k < 100) begin
            check("row_idx", 32'(bus.row_idx), idx);
            bus.parity_check_row = h_rows[bus.row_idx];
            bus.parity_ready     = stall ? (k % 2 == 0) : 1'b1;
            bus.cipher_ready     = (k == 3);
            if (bus.parity_ready) idx++;
            k++;
            @(negedge clk);
        end
        bus.parity_ready = 1'b0;
        bus.cipher_ready = 1'b0;
        check("rows_accepted", idx, N_ROWS);
        wait_ready(30);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                = 1'b0;
        bus.start            = 1'b0;
        bus.cipher_ready     = 1'b0;
        bus.cipher           = '0;
        bus.parity_ready     = 1'b0;
        bus.parity_check_row = '0;
        repeat (2) @(negedge clk);
        check("rst_syndrome", 32'(bus.syndrome), 0);
        check("rst_ready", 32'(bus.syndrome_ready), 0);
        check("rst_error_free", 32'(bus.error_free), 0);
        check("rst_row_req", 32'(bus.row_req), 0);
        check("rst_row_idx", 32'(bus.row_idx), 0);
        reset = 1'b1;
        bus.cipher_ready = 1'b1;
        bus.parity_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_row_req", 32'(bus.row_req), 0);
        bus.cipher_ready = 1'b0;
        bus.parity_ready = 1'b0;

        // zero cipher, random H
        for (int r = 0; r < N_ROWS; r++) h_rows[r] = cw_t'($urandom);
        do_op(21'h0, 1'b0, 0, 12'h000, 13);

        // single error at bit 0, H column 0 set in rows 0 and 5
        for (int r = 0; r < N_ROWS; r++)
            h_rows[r] = (cw_t'($urandom) & ~cw_t'(1)) | cw_t'((r == 0 || r == 5) ? 1 : 0);
        do_op(21'h000001, 1'b0, 0, 12'h021, 13);
        do_op(21'h000001, 1'b1, 0, 12'h021, 24);

        // rows offered before the cipher; cipher bits 0,1 hit rows 1,2,11
        for (int r = 0; r < N_ROWS; r++) h_rows[r] = cw_t'($urandom) & ~cw_t'(3);
        h_rows[1]  = h_rows[1]  | cw_t'(2);
        h_rows[2]  = h_rows[2]  | cw_t'(3);
        h_rows[11] = h_rows[11] | cw_t'(1);
        do_op(21'h000003, 1'b0, 5, 12'h802, 13);

        // abort after six rows, then all-ones run
        for (int r = 0; r < N_ROWS; r++) h_rows[r] = '1;
        start_and_latch(21'h1FFFFF, 0);
        bus.parity_check_row = '1;
        bus.parity_ready     = 1'b1;
        repeat (6) @(negedge clk);
        bus.parity_ready = 1'b0;
        check("partial_syndrome", 32'(bus.syndrome), 32'h03F);
        check("partial_row_idx", 32'(bus.row_idx), 6);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_syndrome", 32'(bus.syndrome), 0);
        check("abort_ready", 32'(bus.syndrome_ready), 0);
        check("abort_row_req", 32'(bus.row_req), 0);
        check("abort_row_idx", 32'(bus.row_idx), 0);
        do_op(21'h1FFFFF, 1'b0, 0, 12'hFFF, 13);

        // asynchronous reset between edges mid-accumulation
        start_and_latch(21'h1FFFFF, 0);
        bus.parity_check_row = '1;
        bus.parity_ready     = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_syndrome", 32'(bus.syndrome), 32'h007);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("areset_syndrome", 32'(bus.syndrome), 0);
        check("areset_ready", 32'(bus.syndrome_ready), 0);
        check("areset_error_free", 32'(bus.error_free), 0);
        check("areset_row_req", 32'(bus.row_req), 0);
        check("areset_row_idx", 32'(bus.row_idx), 0);
        @(negedge clk);
        reset = 1'b1;
        bus.cipher_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_row_req", 32'(bus.row_req), 0);
            check("post_reset_ready", 32'(bus.syndrome_ready), 0);
            check("post_reset_syndrome", 32'(bus.syndrome), 0);
        end
        bus.cipher_ready = 1'b0;
        bus.parity_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/syndrome_gen.md
Name: syndrome_gen

Overview:
Decoder-side counterpart of the encryption datapath. It latches the ciphertext produced by encryption and streams the N parity-check rows in, one per accepted cycle. For each row it forms one syndrome bit, the XOR-reduction of row AND cipher, and assembles the N-bit syndrome. The result feeds the error-locator/decoding stage inside decryption.

Parameters:
q, 3, code field/block parameter (same meaning as pars.vh)
t, 2, error-correction capability (same meaning as pars.vh)
n, q*q, message length (derived, not overridden)
N, 2*t*q, parity rows = syndrome width (derived)
K, n+N, codeword/cipher length (derived)
logN, 4, row-counter width; must satisfy 2^logN > N

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; (re)starts an operation from any state
cipher_ready  input  1  cipher valid strobe from encryption
cipher  input  K  ciphertext vector
parity_ready  input  1  parity_check_row valid this cycle
parity_check_row  input  K  one row of H, bit i pairs with cipher[i]
row_req  output  1  block accepts a row this cycle when parity_ready=1
row_idx  output  logN  index of the row currently requested
syndrome  output  N  syndrome vector; bit r = result of row r
syndrome_ready  output  1  level; result valid
error_free  output  1  level; syndrome==0, valid only with syndrome_ready

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; cipher register 0; row counter 0.
- States: IDLE, WAIT_CIPHER, ACCUM, DONE.
- IDLE: start -> WAIT_CIPHER. Clear syndrome, syndrome_ready, error_free and the counter on the same edge.
- WAIT_CIPHER: cipher_ready=1 latches cipher -> ACCUM. parity_ready is ignored here. If start and cipher_ready coincide in IDLE, only start acts; cipher_ready is sampled from the next cycle.
- ACCUM: row_req=1 and row_idx=counter.
  - Row accepted when row_req and parity_ready: syndrome[counter] <= ^(parity_check_row & cipher_reg); counter++.
  - parity_ready=0 stalls; counter and syndrome hold.
  - Accepting row N-1 -> DONE on the next edge. The counter never exceeds N-1 and has no wrap-around.
  - cipher_ready pulses during ACCUM are ignored; the cipher register holds.
- DONE: row_req=0. syndrome_ready=1 and error_free=(syndrome==0) from the first DONE cycle until the next start or reset.
  - Latency: syndrome_ready rises 1 cycle after the edge that accepts the last row. The no-stall minimum is N+1 cycles after the cipher is latched.
- start in any non-IDLE state: abort, clear as in IDLE, -> WAIT_CIPHER. start has priority over every other event in that cycle.
- Outputs are registered, except row_req and row_idx, which are decoded from state and counter.

Decomposition:
- Shared package/header (pars.vh): q, t, logN, derived n/N/K, and localparams for the state encoding (2 bits).
- One sub-module is natural: parity_dot (combinational, K-bit AND + XOR-reduce -> 1 bit). It is reusable by encryption checks and the decoder. Everything else stays in syndrome_gen.

Test Plan:
1. Zero cipher: start, cipher=21'h0, 12 rows of random H with parity_ready held high -> syndrome=12'h000, error_free=1, syndrome_ready high exactly 13 cycles after cipher latch.
2. Single error: cipher=21'h000001; rows 0 and 5 have bit0=1, all other rows bit0=0 -> syndrome=12'h021, error_free=0.
3. Stalls: repeat case 2 with parity_ready toggling 1/0 every cycle -> same syndrome=12'h021; row_idx advances only on accepted cycles; ready after 24 cycles.
4. Early rows and late cipher: parity_ready=1 during WAIT_CIPHER for 5 cycles -> no rows consumed, row_idx=0 when ACCUM begins, result matches the reference model.
5. Restart mid-ACCUM: start after 6 accepted rows -> syndrome cleared to 0, syndrome_ready=0, back in WAIT_CIPHER. A new cipher=21'h1FFFFF with an all-ones H gives syndrome=12'hFFF (21 ones -> odd parity).
6. Async reset: drive reset=0 mid-ACCUM between clock edges -> all outputs 0 immediately. After release, no activity until start.
